// File: rtl/mux_vector_sequencer_pkg.sv
// Shared constants for the 2:1 mux self-test sequencer: FSM encoding,
// sweep length and where each mux input sits inside the vector index.
package mux_vector_sequencer_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int NUM_VECTORS = 8;
  localparam int X_BIT = 2;
  localparam int Y_BIT = 1;
  localparam int S_BIT = 0;
endpackage

// File: rtl/mux_golden.sv
// Independent reference model of the 2:1 mux, so the checker never trusts
// the device it is testing.
module mux_golden (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic exp
);
  assign exp = sel ? b : a;
endmodule

// File: rtl/mux_vector_sequencer.sv
// Sweeps all 8 {a,b,sel} vectors into an external 2:1 mux, samples z_in
// after SETTLE_CYCLES and records error count and the first failing vector.
module mux_vector_sequencer
  import mux_vector_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       x_out,
  output logic       y_out,
  output logic       sel_out,
  input  logic       z_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_valid,
  output logic [2:0] fail_idx
);
  localparam logic [3:0] RELOAD   = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] LAST_IDX = 3'(NUM_VECTORS - 1);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] stim_q, stim_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] err_q, err_d;
  logic [2:0] fidx_q, fidx_d;
  logic       fvld_q, fvld_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       exp_w;

  // Golden value is taken from the registered stimulus actually on the pins.
  mux_golden u_golden (
    .a   (stim_q[X_BIT]),
    .b   (stim_q[Y_BIT]),
    .sel (stim_q[S_BIT]),
    .exp (exp_w)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    fvld_d  = fvld_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          idx_d   = 3'd0;
          stim_d  = 3'd0;
          err_d   = 4'd0;
          fidx_d  = 3'd0;
          fvld_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = RELOAD;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (z_in != exp_w) begin
            err_d = err_q + 4'd1;
            if (!fvld_q) begin
              fidx_d = idx_q;
              fvld_d = 1'b1;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 4'd0);
            stim_d  = 3'd0;
          end else begin
            idx_d  = idx_q + 3'd1;
            stim_d = idx_d;
            cnt_d  = RELOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      stim_q  <= 3'd0;
      cnt_q   <= 4'd0;
      err_q   <= 4'd0;
      fidx_q  <= 3'd0;
      fvld_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fvld_q  <= fvld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign x_out      = stim_q[X_BIT];
  assign y_out      = stim_q[Y_BIT];
  assign sel_out    = stim_q[S_BIT];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fvld_q;
  assign fail_idx   = fidx_q;
endmodule

// File: tb/tb_mux_vector_sequencer.sv
// Scoreboard bench: two sequencers (settle 1 and 3) each looped back
// through a behavioural mux whose fault mode is selectable.
module tb_mux_vector_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [1:0]      start_v, x_v, y_v, s_v, z_v, busy_v, done_v, pass_v, fv_v;
  logic [1:0][3:0] ec_v;
  logic [1:0][2:0] fi_v;
  int              mode;

  typedef struct {
    logic [3:0] err;
    logic [2:0] fidx;
    logic       fvld;
    logic       pass;
  } res_t;
  res_t sbq[$];

  int nchk = 0;
  int nerr = 0;

  // mode 0 good mux, 1 stuck-at-0, 2 stuck-at-1, 3 inverted
  function automatic logic mux_ut(input int m, input logic x, input logic y, input logic s);
    logic g;
    g = s ? y : x;
    case (m)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return ~g;
      default: return g;
    endcase
  endfunction

  assign z_v[0] = mux_ut(mode, x_v[0], y_v[0], s_v[0]);
  assign z_v[1] = mux_ut(mode, x_v[1], y_v[1], s_v[1]);

  mux_vector_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .x_out(x_v[0]), .y_out(y_v[0]), .sel_out(s_v[0]), .z_in(z_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_count(ec_v[0]), .fail_valid(fv_v[0]), .fail_idx(fi_v[0])
  );

  mux_vector_sequencer #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .x_out(x_v[1]), .y_out(y_v[1]), .sel_out(s_v[1]), .z_in(z_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_count(ec_v[1]), .fail_valid(fv_v[1]), .fail_idx(fi_v[1])
  );

  task automatic chk(input string tag, input int got, input int want);
    nchk++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic push_expect(input int m);
    res_t r;
    logic [2:0] v;
    logic e, z;
    r.err = 4'd0; r.fidx = 3'd0; r.fvld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      e = v[0] ? v[1] : v[2];
      z = (m == 1) ? 1'b0 : (m == 2) ? 1'b1 : (m == 3) ? ~e : e;
      if (z != e) begin
        if (!r.fvld) begin r.fidx = v; r.fvld = 1'b1; end
        r.err = r.err + 4'd1;
      end
    end
    r.pass = (r.err == 4'd0);
    sbq.push_back(r);
  endtask

  task automatic chk_idle(input int w, input string tag);
    chk({tag, "_busy"}, int'(busy_v[w]), 0);
    chk({tag, "_done"}, int'(done_v[w]), 0);
    chk({tag, "_pass"}, int'(pass_v[w]), 0);
    chk({tag, "_err"},  int'(ec_v[w]), 0);
    chk({tag, "_fv"},   int'(fv_v[w]), 0);
    chk({tag, "_fi"},   int'(fi_v[w]), 0);
    chk({tag, "_stim"}, int'({x_v[w], y_v[w], s_v[w]}), 0);
  endtask

  // rst_at >= 0 aborts the sweep with a one-edge reset at that cycle.
  task automatic sweep(input int w, input int m, input bit pulse, input int rst_at);
    int   S, n, bcnt;
    res_t r;
    S = (w != 0) ? 3 : 1;
    n = 0;
    bcnt = 0;
    mode = m;
    if (rst_at < 0) push_expect(m);
    start_v[w] = 1'b1;
    @(negedge clk);
    start_v[w] = 1'b0;
    chk("done_clr", int'(done_v[w]), 0);
    while (!done_v[w] && n < 400) begin
      if (busy_v[w]) begin
        bcnt++;
        chk("vec", int'({x_v[w], y_v[w], s_v[w]}), (n / S) % 8);
      end
      if (rst_at == n) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_idle(w, "abort");
        return;
      end
      start_v[w] = pulse && (n == 2 || n == 10);
      @(negedge clk);
      start_v[w] = 1'b0;
      n++;
    end
    chk("done_lat", n, 8 * S);
    chk("busy_cyc", bcnt, 8 * S);
    chk("busy_end", int'(busy_v[w]), 0);
    chk("stim_end", int'({x_v[w], y_v[w], s_v[w]}), 0);
    if (sbq.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      r = sbq.pop_front();
      chk("err_count", int'(ec_v[w]), int'(r.err));
      chk("fail_valid", int'(fv_v[w]), int'(r.fvld));
      chk("pass", int'(pass_v[w]), int'(r.pass));
      if (r.fvld) chk("fail_idx", int'(fi_v[w]), int'(r.fidx));
    end
  endtask

  initial begin
    mode = 0;
    start_v = 2'b00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle(0, "rst1");
    chk_idle(1, "rst3");
    rst_n = 1'b1;
    @(negedge clk);
    sweep(0, 0, 1'b0, -1);
    sweep(0, 1, 1'b0, -1);
    sweep(0, 2, 1'b0, -1);
    sweep(0, 3, 1'b0, -1);
    sweep(1, 0, 1'b1, -1);
    sweep(1, 3, 1'b0, -1);
    sweep(0, 0, 1'b0, 4);
    @(negedge clk);
    sweep(0, 0, 1'b0, -1);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
